cmps_uop_sequencer: RTL and testbench

Upstream uop sequencer that feeds the EX→WB pipeline with the CMPS first/second uop markers the writeback stage consumes (`CS_IS_CMPS_FIRST_UOP_ALL`, `CS_IS_CMPS_SECOND_UOP_ALL`, `WB_de_repne_wb`). It consumes writeback's `repne_terminate_all` and `halt_all`. It splits each CMPS into two uops and replays the pair for REPNE until writeback signals termination. Non-CMPS instructions pass through as a single uop. Halt freezes issue.

---
 rtl/cmps_uop_sequencer_pkg.sv | 32 +++
 rtl/cmps_uop_sequencer_sat_counter.sv | 28 ++
 rtl/cmps_uop_sequencer.sv | 126 ++++++++++++
 tb/tb_cmps_uop_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmps_uop_sequencer_pkg.sv
// Shared types for the CMPS uop sequencer: FSM state encoding and the
// presented-uop record {v, first, second, repne}.
package cmps_uop_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FIRST  = 3'd1,
        ST_SECOND = 3'd2,
        ST_WAIT   = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    typedef struct packed {
        logic v;
        logic first;
        logic second;
        logic repne;
    } uop_t;

    localparam uop_t UOP_NONE = '{v: 1'b0, first: 1'b0, second: 1'b0, repne: 1'b0};

    function automatic uop_t make_uop(input logic v, input logic first,
                                      input logic second, input logic repne);
        uop_t u;
        u.v      = v;
        u.first  = first;
        u.second = second;
        u.repne  = repne;
        return u;
    endfunction

endpackage

// File: rtl/cmps_uop_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = W'(1);

    // Iteration count: clear, saturating increment, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= {W{1'b0}};
        end else if (clr) begin
            cnt <= {W{1'b0}};
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/cmps_uop_sequencer.sv
// Splits CMPS into first/second uops, replays REPNE pairs until writeback
// terminates the loop, passes other instructions through, freezes on halt.
module cmps_uop_sequencer
    import cmps_uop_sequencer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             DE_V,
    input  logic             DE_IS_CMPS,
    input  logic             DE_REPNE,
    input  logic             DE_ECX_ZERO,
    input  logic             STALL_IN,
    input  logic             FLUSH,
    input  logic             WB_CMPS_DONE,
    input  logic             REPNE_TERMINATE_ALL,
    input  logic             HALT_ALL,
    output logic             DE_READY,
    output logic             UOP_V,
    output logic             UOP_IS_CMPS_FIRST,
    output logic             UOP_IS_CMPS_SECOND,
    output logic             UOP_REPNE,
    output logic [CNT_W-1:0] ITER_CNT,
    output logic             HALTED
);

    state_e state_r;
    uop_t   uop_r;
    logic   halted_r;
    logic   ready_s;
    logic   accept_s;
    logic   cnt_clr_s;
    logic   cnt_inc_s;

    assign ready_s   = ((state_r == ST_IDLE) | ((state_r == ST_SECOND) & ~uop_r.repne))
                       & ~STALL_IN & ~FLUSH & ~HALT_ALL;
    assign accept_s  = DE_V & ready_s;
    assign cnt_clr_s = accept_s & DE_IS_CMPS & DE_REPNE;
    // A REPNE second uop counts as an iteration once downstream takes it
    assign cnt_inc_s = (state_r == ST_SECOND) & uop_r.repne & ~STALL_IN & ~FLUSH & ~HALT_ALL;

    // Sequencer FSM together with the registered uop presentation
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_r  <= ST_IDLE;
            uop_r    <= UOP_NONE;
            halted_r <= 1'b0;
        end else if (HALT_ALL || (state_r == ST_HALT)) begin
            state_r  <= ST_HALT;
            uop_r    <= UOP_NONE;
            halted_r <= 1'b1;
        end else if (FLUSH) begin
            state_r <= ST_IDLE;
            uop_r   <= UOP_NONE;
        end else if (state_r == ST_WAIT) begin
            // Writeback sits past the stall point, so WAIT listens even when stalled;
            // a replay under stall leaves FIRST pending with V=0 until the stall drops.
            if (WB_CMPS_DONE) begin
                state_r <= REPNE_TERMINATE_ALL ? ST_IDLE : ST_FIRST;
                if (!STALL_IN) begin
                    uop_r <= REPNE_TERMINATE_ALL ? UOP_NONE
                                                 : make_uop(1'b1, 1'b1, 1'b0, 1'b1);
                end else begin
                    uop_r <= uop_r;
                end
            end else begin
                state_r <= state_r;
            end
        end else if (!STALL_IN) begin
            case (state_r)
                ST_IDLE, ST_SECOND: begin
                    if ((state_r == ST_SECOND) && uop_r.repne) begin
                        state_r <= ST_WAIT;
                        uop_r   <= make_uop(1'b0, 1'b0, 1'b0, 1'b1);
                    end else if (accept_s && !DE_IS_CMPS) begin
                        state_r <= ST_IDLE;
                        uop_r   <= make_uop(1'b1, 1'b0, 1'b0, 1'b0);
                    end else if (accept_s && !DE_REPNE) begin
                        state_r <= ST_FIRST;
                        uop_r   <= make_uop(1'b1, 1'b1, 1'b0, 1'b0);
                    end else if (accept_s && !DE_ECX_ZERO) begin
                        state_r <= ST_FIRST;
                        uop_r   <= make_uop(1'b1, 1'b1, 1'b0, 1'b1);
                    end else begin
                        state_r <= ST_IDLE;
                        uop_r   <= UOP_NONE;
                    end
                end
                ST_FIRST: begin
                    if (!uop_r.v) begin
                        uop_r <= make_uop(1'b1, 1'b1, 1'b0, uop_r.repne);
                    end else begin
                        state_r <= ST_SECOND;
                        uop_r   <= make_uop(1'b1, 1'b0, 1'b1, uop_r.repne);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    uop_r   <= UOP_NONE;
                end
            endcase
        end else begin
            state_r <= state_r;
            uop_r   <= uop_r;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_iter_cnt (
        .clk   (CLK),
        .rst_n (CLR),
        .clr   (cnt_clr_s),
        .inc   (cnt_inc_s),
        .cnt   (ITER_CNT)
    );

    assign DE_READY           = ready_s;
    assign UOP_V              = uop_r.v;
    assign UOP_IS_CMPS_FIRST  = uop_r.first;
    assign UOP_IS_CMPS_SECOND = uop_r.second;
    assign UOP_REPNE          = uop_r.repne;
    assign HALTED             = halted_r;

endmodule

// File: tb/tb_cmps_uop_sequencer.sv
// Bench for cmps_uop_sequencer: directed vector table, random stimulus against a
// queue-based reference model, and hand sequences for saturation and halt/reset.
module tb_cmps_uop_sequencer;

    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic CLK = 1'b0;
    logic clr = 1'b0;
    logic de_v = 1'b0, de_is_cmps = 1'b0, de_repne = 1'b0, de_ecx_zero = 1'b0;
    logic stall = 1'b0, flush = 1'b0, done = 1'b0, term = 1'b0, halt = 1'b0;
    logic de_ready, uop_v, uop_first, uop_second, uop_repne, halted;
    logic [CNT_W-1:0] iter_cnt;

    int checks = 0;
    int errors = 0;

    cmps_uop_sequencer #(.CNT_W(CNT_W)) dut (
        .CLK                 (CLK),
        .CLR                 (clr),
        .DE_V                (de_v),
        .DE_IS_CMPS          (de_is_cmps),
        .DE_REPNE            (de_repne),
        .DE_ECX_ZERO         (de_ecx_zero),
        .STALL_IN            (stall),
        .FLUSH               (flush),
        .WB_CMPS_DONE        (done),
        .REPNE_TERMINATE_ALL (term),
        .HALT_ALL            (halt),
        .DE_READY            (de_ready),
        .UOP_V               (uop_v),
        .UOP_IS_CMPS_FIRST   (uop_first),
        .UOP_IS_CMPS_SECOND  (uop_second),
        .UOP_REPNE           (uop_repne),
        .ITER_CNT            (iter_cnt),
        .HALTED              (halted)
    );

    always #5 CLK = ~CLK;

    // Reference model: uops still owed downstream sit in a queue
    typedef struct packed { logic v; logic f; logic s; logic r; } muop_t;
    muop_t m_q[$];
    muop_t m_cur;
    bit    m_wait;
    bit    m_halted;
    int    m_cnt;

    typedef struct {
        logic [8:0] in;   // {v, cmps, repne, ecx0, stall, flush, done, term, halt}
        logic       rdy;
        logic [3:0] uop;  // {v, first, second, repne} after the edge
        int         it;
        logic       hl;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cur    = '0;
        m_wait   = 1'b0;
        m_halted = 1'b0;
        m_cnt    = 0;
    endtask

    function automatic logic model_rdy();
        return !m_halted && !m_wait && (m_q.size() == 0) && !(m_cur.v && m_cur.s && m_cur.r)
               && !stall && !flush && !halt;
    endfunction

    task automatic model_step(input logic rdy);
        if (m_halted || halt) begin
            m_halted = 1'b1;
            m_cur    = '0;
            m_wait   = 1'b0;
            m_q.delete();
        end else if (flush) begin
            m_cur  = '0;
            m_wait = 1'b0;
            m_q.delete();
        end else if (m_wait) begin
            if (done) begin
                m_wait = 1'b0;
                if (!term) begin
                    m_q.push_back(muop_t'(4'b1101));
                    m_q.push_back(muop_t'(4'b1011));
                end
                if (!stall) m_cur = (m_q.size() > 0) ? m_q.pop_front() : muop_t'(4'b0000);
            end
        end else if (!stall) begin
            if (m_cur.v && m_cur.s && m_cur.r) begin
                if (m_cnt < CMAX) m_cnt++;
                m_wait = 1'b1;
                m_cur  = muop_t'(4'b0001);
            end else begin
                if (de_v && rdy) begin
                    if (!de_is_cmps) begin
                        m_q.push_back(muop_t'(4'b1000));
                    end else if (!de_repne) begin
                        m_q.push_back(muop_t'(4'b1100));
                        m_q.push_back(muop_t'(4'b1010));
                    end else begin
                        m_cnt = 0;
                        if (!de_ecx_zero) begin
                            m_q.push_back(muop_t'(4'b1101));
                            m_q.push_back(muop_t'(4'b1011));
                        end
                    end
                end
                m_cur = (m_q.size() > 0) ? m_q.pop_front() : muop_t'(4'b0000);
            end
        end
    endtask

    task automatic set_in(input logic [8:0] in);
        {de_v, de_is_cmps, de_repne, de_ecx_zero, stall, flush, done, term, halt} = in;
    endtask

    // One clock: check DE_READY before the edge, registered outputs after it
    task automatic cycle(input bit use_vec, input vec_t e);
        logic rdy_m;
        #1;
        rdy_m = model_rdy();
        check("de_ready_model", 32'(de_ready), 32'(rdy_m));
        if (use_vec) check("de_ready_vec", 32'(de_ready), 32'(e.rdy));
        @(posedge CLK);
        model_step(rdy_m);
        #1;
        check("uop_model", 32'({uop_v, uop_first, uop_second, uop_repne}), 32'(m_cur));
        check("iter_model", 32'(iter_cnt), 32'(m_cnt));
        check("halted_model", 32'(halted), 32'(m_halted));
        if (use_vec) begin
            check("uop_vec", 32'({uop_v, uop_first, uop_second, uop_repne}), 32'(e.uop));
            check("iter_vec", 32'(iter_cnt), 32'(e.it));
            check("halted_vec", 32'(halted), 32'(e.hl));
        end
    endtask

    task automatic step(input logic [8:0] in);
        vec_t dummy;
        dummy = '{in: 9'd0, rdy: 1'b0, uop: 4'd0, it: 0, hl: 1'b0};
        set_in(in);
        cycle(1'b0, dummy);
    endtask

    task automatic pulse_clr(input string name);
        clr = 1'b0;
        #1;
        check(name, 32'({uop_v, uop_first, uop_second, uop_repne, halted, iter_cnt}), 32'd0);
        model_reset();
        clr = 1'b1;
    endtask

    function automatic vec_t mk(input logic [8:0] in, input logic rdy, input logic [3:0] uop,
                                input int it, input logic hl);
        vec_t v;
        v.in = in; v.rdy = rdy; v.uop = uop; v.it = it; v.hl = hl;
        return v;
    endfunction

    initial begin
        localparam logic [8:0] IDLE = 9'b000000000, NCMP = 9'b100000000, CMPS = 9'b110000000;
        localparam logic [8:0] REPZ = 9'b111100000, REPN = 9'b111000000, DNT = 9'b000000100;
        localparam logic [8:0] DTM = 9'b000000110, STL = 9'b000010000, FLS = 9'b000001000;
        localparam logic [8:0] HFL = 9'b000001001;

        // Non-CMPS, back-to-back plain CMPS, REPNE with ECX=0
        tbl.push_back(mk(NCMP, 1'b1, 4'b1000, 0, 1'b0));
        tbl.push_back(mk(IDLE, 1'b1, 4'b0000, 0, 1'b0));
        tbl.push_back(mk(CMPS, 1'b1, 4'b1100, 0, 1'b0));
        tbl.push_back(mk(IDLE, 1'b0, 4'b1010, 0, 1'b0));
        tbl.push_back(mk(NCMP, 1'b1, 4'b1000, 0, 1'b0));
        tbl.push_back(mk(IDLE, 1'b1, 4'b0000, 0, 1'b0));
        tbl.push_back(mk(REPZ, 1'b1, 4'b0000, 0, 1'b0));
        tbl.push_back(mk(IDLE, 1'b1, 4'b0000, 0, 1'b0));
        // REPNE with three writeback completions, terminating on the third
        tbl.push_back(mk(REPN, 1'b1, 4'b1101, 0, 1'b0));
        tbl.push_back(mk(IDLE, 1'b0, 4'b1011, 0, 1'b0));
        tbl.push_back(mk(IDLE, 1'b0, 4'b0001, 1, 1'b0));
        tbl.push_back(mk(DNT,  1'b0, 4'b1101, 1, 1'b0));
        tbl.push_back(mk(IDLE, 1'b0, 4'b1011, 1, 1'b0));
        tbl.push_back(mk(IDLE, 1'b0, 4'b0001, 2, 1'b0));
        tbl.push_back(mk(IDLE, 1'b0, 4'b0001, 2, 1'b0));
        tbl.push_back(mk(DNT,  1'b0, 4'b1101, 2, 1'b0));
        tbl.push_back(mk(IDLE, 1'b0, 4'b1011, 2, 1'b0));
        tbl.push_back(mk(IDLE, 1'b0, 4'b0001, 3, 1'b0));
        tbl.push_back(mk(DTM,  1'b0, 4'b0000, 3, 1'b0));
        tbl.push_back(mk(IDLE, 1'b1, 4'b0000, 3, 1'b0));
        // Stall held in SECOND, then flush in WAIT
        tbl.push_back(mk(REPN, 1'b1, 4'b1101, 0, 1'b0));
        tbl.push_back(mk(IDLE, 1'b0, 4'b1011, 0, 1'b0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(STL, 1'b0, 4'b1011, 0, 1'b0));
        tbl.push_back(mk(IDLE, 1'b0, 4'b0001, 1, 1'b0));
        tbl.push_back(mk(FLS,  1'b0, 4'b0000, 1, 1'b0));
        tbl.push_back(mk(IDLE, 1'b1, 4'b0000, 1, 1'b0));
        // Halt with simultaneous flush during FIRST
        tbl.push_back(mk(CMPS, 1'b1, 4'b1100, 1, 1'b0));
        tbl.push_back(mk(HFL,  1'b0, 4'b0000, 1, 1'b1));
        tbl.push_back(mk(NCMP, 1'b0, 4'b0000, 1, 1'b1));

        model_reset();
        #12;
        check("reset_outputs", 32'({uop_v, uop_first, uop_second, uop_repne, halted, iter_cnt}), 32'd0);
        clr = 1'b1;
        @(posedge CLK);
        #1;

        foreach (tbl[i]) begin
            set_in(tbl[i].in);
            cycle(1'b1, tbl[i]);
        end

        set_in(IDLE);
        pulse_clr("clr_after_halt");

        for (int n = 0; n < 3000; n++) begin
            de_v        = ($urandom_range(0, 99) < 60);
            de_is_cmps  = ($urandom_range(0, 1) == 1);
            de_repne    = ($urandom_range(0, 1) == 1);
            de_ecx_zero = ($urandom_range(0, 99) < 20);
            stall       = ($urandom_range(0, 99) < 25);
            flush       = ($urandom_range(0, 99) < 4);
            done        = ($urandom_range(0, 99) < 30);
            term        = ($urandom_range(0, 1) == 1);
            halt        = 1'b0;
            step({de_v, de_is_cmps, de_repne, de_ecx_zero, stall, flush, done, term, halt});
        end

        // Asynchronous clear wherever the random run left the sequencer
        set_in(IDLE);
        pulse_clr("clr_mid_sequence");

        // Nine REPNE iterations saturate a 3-bit counter at 7
        step(REPN);
        step(IDLE);
        step(IDLE);
        for (int k = 0; k < 8; k++) begin
            step(DNT);
            step(IDLE);
            step(IDLE);
        end
        check("iter_saturated", 32'(iter_cnt), 32'(CMAX));

        // Halt and writeback completion together in WAIT: halt wins
        step(9'b000000101);
        check("halt_wins_over_done", 32'({halted, uop_v, de_ready}), 32'b100);
        step(NCMP);
        step(IDLE);
        pulse_clr("clr_from_halt");
        step(NCMP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
